// File: rtl/i2s_capture.sv
// rtl/i2s_capture.sv - I2S slave receiver packing {right, left} stereo pairs into a circular capture buffer.
module i2s_capture #(
    parameter int WORD_BITS   = 16,
    parameter int ADDR_BITS   = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clkin,
    input  logic                 reset,
    input  logic                 sclk_in,
    input  logic                 lrck_in,
    input  logic                 sdin,
    input  logic                 cap_en,
    input  logic [ADDR_BITS-1:0] addr_ext,
    output logic                 buf_we,
    output logic [ADDR_BITS-1:0] buf_addr,
    output logic [31:0]          buf_data,
    output logic                 cap_status,
    output logic                 frame_err,
    output logic [15:0]          pair_cnt
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic [SYNC_STAGES-1:0] sdin_sync;
    logic                   sclk_hist;

    logic                 sclk_rise;
    logic                 lrck_s;
    logic                 sdin_s;
    logic [WORD_BITS-1:0] word;

    logic [WORD_BITS-2:0] shreg;
    logic [4:0]           bitcnt;
    logic                 lrck_prev;
    logic                 first_slot;
    logic                 left_valid;
    logic [WORD_BITS-1:0] left_r;

    // Pure synchronizers: no reset, so a reset never fabricates an sclk edge.
    always_ff @(posedge clkin) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
        lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck_in};
        sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
        sclk_hist <= sclk_sync[SYNC_STAGES-1];
    end

    assign sclk_rise  = !sclk_hist && sclk_sync[SYNC_STAGES-1];
    assign lrck_s     = lrck_sync[SYNC_STAGES-1];
    assign sdin_s     = sdin_sync[SYNC_STAGES-1];
    assign word       = {shreg, sdin_s};
    assign cap_status = buf_addr[ADDR_BITS-1];

    always_ff @(posedge clkin) begin
        if (reset) begin
            buf_we     <= 1'b0;
            buf_addr   <= addr_ext;
            buf_data   <= '0;
            frame_err  <= 1'b0;
            pair_cnt   <= '0;
            shreg      <= '0;
            bitcnt     <= '0;
            lrck_prev  <= 1'b0;
            first_slot <= 1'b1;
            left_valid <= 1'b0;
            left_r     <= '0;
        end else begin
            buf_we <= 1'b0;
            if (buf_we) begin
                buf_addr <= buf_addr + ADDR_BITS'(1);
                pair_cnt <= pair_cnt + 16'd1;
            end
            if (sclk_rise) begin
                shreg     <= word[WORD_BITS-2:0];
                lrck_prev <= lrck_s;
                if (lrck_s != lrck_prev) begin
                    // The edge rise carries the old slot's LSB, so bitcnt already
                    // equals the ending slot's length; restarting at 1 keeps that true.
                    bitcnt     <= 5'd1;
                    first_slot <= 1'b0;
                    if (first_slot) begin
                        left_valid <= 1'b0;
                    end else if (bitcnt != 5'(WORD_BITS)) begin
                        frame_err  <= 1'b1;
                        left_valid <= 1'b0;
                    end else if (!lrck_prev) begin
                        if (cap_en) begin
                            left_r <= word;
                        end
                        left_valid <= cap_en;
                    end else begin
                        left_valid <= 1'b0;
                        if (left_valid && cap_en) begin
                            buf_data <= {word, left_r};
                            buf_we   <= 1'b1;
                        end
                    end
                end else if (bitcnt != 5'd31) begin
                    bitcnt <= bitcnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_capture.sv
// tb/tb_i2s_capture.sv - scoreboard bench for i2s_capture: framing, wrap, errors, gating and reset collisions.
module tb_i2s_capture;

    logic        clkin = 1'b0;
    logic        reset = 1'b1;
    logic        sclk_in = 1'b0;
    logic        lrck_in = 1'b0;
    logic        sdin = 1'b0;
    logic        cap_en = 1'b1;
    logic [8:0]  addr_ext = 9'h000;
    logic        buf_we;
    logic [8:0]  buf_addr;
    logic [31:0] buf_data;
    logic        cap_status;
    logic        frame_err;
    logic [15:0] pair_cnt;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [40:0] sb[$];
    logic [40:0] exp_w;
    logic [8:0]  exp_addr = 9'h000;
    logic        carry = 1'b0;
    logic        prev_we = 1'b0;

    i2s_capture dut (
        .clkin(clkin), .reset(reset), .sclk_in(sclk_in), .lrck_in(lrck_in), .sdin(sdin),
        .cap_en(cap_en), .addr_ext(addr_ext), .buf_we(buf_we), .buf_addr(buf_addr),
        .buf_data(buf_data), .cap_status(cap_status), .frame_err(frame_err), .pair_cnt(pair_cnt)
    );

    always #5 clkin = ~clkin;

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clkin) begin
        if (buf_we) begin
            n_checks++;
            if (prev_we) begin
                n_fail++;
                $display("FAIL we_back_to_back: buf_we high two cycles, addr=%h", buf_addr);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr=%h data=%h, no write expected", buf_addr, buf_data);
            end else begin
                exp_w = sb.pop_front();
                if ({buf_addr, buf_data} !== exp_w) begin
                    n_fail++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                             buf_addr, buf_data, exp_w[40:32], exp_w[31:0]);
                end
            end
        end
        prev_we = buf_we;
    end

    task automatic drive_period(input logic lr, input logic b);
        @(negedge clkin);
        sclk_in = 1'b0;
        lrck_in = lr;
        sdin    = b;
        repeat (8) @(negedge clkin);
        sclk_in = 1'b1;
        repeat (7) @(negedge clkin);
    endtask

    // Data lags LRCK by one bit: each period carries the previous slot bit.
    task automatic drive_slot(input logic lr, input logic [15:0] w, input int nbits,
                              input int en_at, input logic en_val);
        for (int i = 0; i < nbits; i++) begin
            if (i == en_at) cap_en = en_val;
            drive_period(lr, carry);
            carry = w[15-i];
        end
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        sb.push_back({exp_addr, r, l});
        exp_addr = exp_addr + 9'd1;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic expect_write);
        if (expect_write) push_pair(l, r);
        drive_slot(1'b0, l, 16, -1, 1'b0);
        drive_slot(1'b1, r, 16, -1, 1'b0);
    endtask

    task automatic flush();
        drive_slot(1'b0, 16'h0000, 2, -1, 1'b0);
    endtask

    task automatic apply_reset(input logic [8:0] a);
        @(negedge clkin);
        reset    = 1'b1;
        addr_ext = a;
        sclk_in  = 1'b0;
        lrck_in  = 1'b0;
        sdin     = 1'b0;
        cap_en   = 1'b1;
        carry    = 1'b0;
        repeat (6) @(negedge clkin);
        reset    = 1'b0;
        exp_addr = a;
        // Preamble right slot absorbs the discarded first slot after reset.
        drive_slot(1'b1, 16'h0000, 16, -1, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clkin);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d writes missing, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clkin);
        reset    = 1'b1;
        addr_ext = 9'h155;
        repeat (4) @(negedge clkin);
        n_checks++;
        if (buf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", buf_we); end
        n_checks++;
        if (buf_addr !== 9'h155) begin n_fail++; $display("FAIL reset_addr: got %h expected 155", buf_addr); end
        n_checks++;
        if (buf_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", buf_data); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        n_checks++;
        if (pair_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", pair_cnt); end
        n_checks++;
        if (cap_status !== 1'b1) begin n_fail++; $display("FAIL reset_status: got %b expected 1", cap_status); end
    endtask

    task automatic test_nominal();
        apply_reset(9'h000);
        for (int f = 0; f < 3; f++) send_frame(16'h1234, 16'hABCD, 1'b1);
        flush();
        wait_drain("nominal");
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL nominal_err: got %b expected 0", frame_err); end
        n_checks++;
        if (pair_cnt !== 16'd3) begin n_fail++; $display("FAIL nominal_cnt: got %0d expected 3", pair_cnt); end
        n_checks++;
        if (buf_addr !== 9'h003) begin n_fail++; $display("FAIL nominal_addr: got %h expected 003", buf_addr); end
    endtask

    task automatic test_wrap();
        apply_reset(9'h1FE);
        n_checks++;
        if (cap_status !== 1'b1) begin n_fail++; $display("FAIL wrap_status_hi: got %b expected 1", cap_status); end
        for (int f = 0; f < 4; f++) send_frame(16'h1111 * 16'(f + 1), 16'hA0A0 + 16'(f), 1'b1);
        flush();
        wait_drain("wrap");
        n_checks++;
        if (pair_cnt !== 16'd4) begin n_fail++; $display("FAIL wrap_cnt: got %0d expected 4", pair_cnt); end
        n_checks++;
        if (buf_addr !== 9'h002) begin n_fail++; $display("FAIL wrap_addr: got %h expected 002", buf_addr); end
        n_checks++;
        if (cap_status !== 1'b0) begin n_fail++; $display("FAIL wrap_status_lo: got %b expected 0", cap_status); end
    endtask

    task automatic test_bad_slot();
        apply_reset(9'h000);
        send_frame(16'h5A5A, 16'hC3C3, 1'b1);
        drive_slot(1'b0, 16'h7777, 15, -1, 1'b0);
        drive_slot(1'b1, 16'h9999, 16, -1, 1'b0);
        send_frame(16'h0F0F, 16'hF0F0, 1'b1);
        flush();
        wait_drain("bad_slot");
        n_checks++;
        if (frame_err !== 1'b1) begin n_fail++; $display("FAIL bad_slot_err: got %b expected 1", frame_err); end
        n_checks++;
        if (pair_cnt !== 16'd2) begin n_fail++; $display("FAIL bad_slot_cnt: got %0d expected 2", pair_cnt); end
    endtask

    task automatic test_cap_en();
        apply_reset(9'h040);
        drive_slot(1'b0, 16'h2468, 16, -1, 1'b0);
        drive_slot(1'b1, 16'h1357, 16, 4, 1'b0);
        cap_en = 1'b0;
        push_pair(16'hBEEF, 16'hCAFE);
        drive_slot(1'b0, 16'hBEEF, 16, 8, 1'b1);
        drive_slot(1'b1, 16'hCAFE, 16, -1, 1'b0);
        flush();
        wait_drain("cap_en");
        n_checks++;
        if (pair_cnt !== 16'd1) begin n_fail++; $display("FAIL cap_en_cnt: got %0d expected 1", pair_cnt); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL cap_en_err: got %b expected 0", frame_err); end
    endtask

    task automatic test_sign();
        apply_reset(9'h100);
        send_frame(16'h8000, 16'h0001, 1'b1);
        flush();
        wait_drain("sign");
        n_checks++;
        if (buf_data !== 32'h00018000) begin n_fail++; $display("FAIL sign_data: got %h expected 00018000", buf_data); end
    endtask

    task automatic test_reset_collide();
        apply_reset(9'h0A0);
        send_frame(16'h1234, 16'hABCD, 1'b0);
        // Open the next left slot by hand so reset lands on the right-slot-end detect cycle.
        @(negedge clkin);
        sclk_in = 1'b0;
        lrck_in = 1'b0;
        sdin    = carry;
        repeat (8) @(negedge clkin);
        sclk_in = 1'b1;
        repeat (2) @(negedge clkin);
        reset = 1'b1;
        @(negedge clkin);
        reset = 1'b0;
        n_checks++;
        if (buf_we !== 1'b0) begin n_fail++; $display("FAIL collide_we: got %b expected 0", buf_we); end
        @(negedge clkin);
        n_checks++;
        if (buf_we !== 1'b0) begin n_fail++; $display("FAIL collide_we_late: got %b expected 0", buf_we); end
        n_checks++;
        if (buf_addr !== 9'h0A0) begin n_fail++; $display("FAIL collide_addr: got %h expected 0a0", buf_addr); end
        repeat (4) @(negedge clkin);
        carry = 1'b0;
        drive_slot(1'b0, 16'h4444, 15, -1, 1'b0);
        drive_slot(1'b1, 16'h5555, 16, -1, 1'b0);
        send_frame(16'h6666, 16'h7777, 1'b1);
        flush();
        wait_drain("collide");
        n_checks++;
        if (pair_cnt !== 16'd1) begin n_fail++; $display("FAIL collide_cnt: got %0d expected 1", pair_cnt); end
        n_checks++;
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL collide_err: got %b expected 0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wrap();
        test_bad_slot();
        test_cap_en();
        test_sign();
        test_reset_collide();
        repeat (20) @(negedge clkin);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
